if_prefetch_stage: RTL

//  Parametrised instruction-fetch stage: successor to the fixed-ROM IF stage.

---
 rtl/arm_pkg.sv | 21 ++
 rtl/if_fetch_fifo.sv | 68 ++++++
 rtl/if_prefetch_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   ADDR_W_DEF / INSTR_W_DEF : default address and instruction widths
//   fetch_state_e            : fetch handshake state (IDLE, WAIT, DROP)
//   fetch_entry_t            : prefetch queue entry at the default widths
package arm_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned INSTR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous prefetch queue.
//   clk, rst     : clock, synchronous active-high reset (control state only)
//   push, wdata  : write one entry (ignored when full)
//   pop          : remove head entry (ignored when empty)
//   flush        : empty the queue; wins over push and pop
//   rdata        : head entry (meaningful only when count != 0)
//   count        : number of valid entries, 0..DEPTH
module if_fetch_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a prefetch queue in front of ID.
//   clk, rst                 : clock, synchronous active-high reset
//   freeze                   : ID stall, holds the head entry
//   Branch_taken, BranchAddr : redirect from EXE; flushes queue and fetch
//   imem_req/addr/gnt        : request handshake, one request outstanding
//   imem_rvalid/rdata        : read response, at least one cycle after gnt
//   Instr_valid, PC, Instruction : head entry to ID (PC = addr + PC_STEP),
//                              PC/Instruction forced to 0 when not valid
module if_prefetch_stage
  import arm_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               Branch_taken,
  input  logic [ADDR_W-1:0]  BranchAddr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               Instr_valid,
  output logic [ADDR_W-1:0]  PC,
  output logic [INSTR_W-1:0] Instruction
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = ADDR_W + INSTR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] next_pc;
  logic              push, pop, flush, not_full;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;

  assign next_pc  = fetch_pc_q + ADDR_W'(PC_STEP);
  assign not_full = count < CW'(DEPTH);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_req   = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Masking with Branch_taken guarantees gnt never coincides with a redirect.
        imem_req = ~rst & not_full & ~Branch_taken;
        if (imem_req && imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          push       = ~Branch_taken;
          fetch_pc_d = next_pc;
          state_d    = IDLE;
        end
      end
      DROP: begin
        // Response of a killed request: swallow it.
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (Branch_taken) begin
      fetch_pc_d = BranchAddr;
      if (state_q == WAIT && !imem_rvalid) state_d = DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign flush = Branch_taken;
  assign pop   = Instr_valid & ~freeze;

  if_fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({next_pc, imem_rdata}),
    .rdata (head),
    .count (count)
  );

  assign imem_addr   = fetch_pc_q;
  assign Instr_valid = (count != '0);
  assign PC          = Instr_valid ? head[EW-1:INSTR_W] : '0;
  assign Instruction = Instr_valid ? head[INSTR_W-1:0] : '0;

endmodule
